// File: rtl/decode_nway_serial_pkg.sv
// Shared types and constants for the N-wide decode stage.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package decode_nway_serial_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_OP_32     = 7'b0111011;
    localparam logic [6:0] OP_OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam logic [2:0]  FN3_PRIV    = 3'b000;
    localparam logic [6:0]  FN7_MULDIV  = 7'b0000001;
    localparam logic [11:0] FN12_ECALL  = 12'h000;
    localparam logic [11:0] FN12_EBREAK = 12'h001;
    localparam logic [11:0] FN12_SRET   = 12'h102;

    localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL        = 4'd8;

    typedef enum logic [2:0] {
        FU_SIMPLE  = 3'd0,
        FU_COMPLEX = 3'd1,
        FU_CTRL    = 3'd2,
        FU_MEM     = 3'd3,
        FU_FP      = 3'd4,
        FU_SYS     = 3'd5
    } fu_t;

    typedef enum logic {
        DEC_IDLE  = 1'b0,
        DEC_SPLIT = 1'b1
    } dec_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } decPkt;

    // Register indices are 6 bits: 0..31 integer, 32..63 floating point.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic [5:0]  logSrc1;
        logic        logSrc1Valid;
        logic [5:0]  logSrc2;
        logic        logSrc2Valid;
        logic [5:0]  logDest;
        logic        logDestValid;
        logic [31:0] imm;
        fu_t         fuType;
        logic        isLoad;
        logic        isStore;
        logic        isCSR;
        logic        isScall;
        logic        isSbreak;
        logic        isSret;
        logic        exception;
        logic [3:0]  exceptionCause;
    } renPkt;

    // Instructions that must reach the instruction buffer in a group of their own.
    function automatic logic is_serializing(input renPkt r);
        return r.isCSR | r.isScall | r.isSbreak | r.isSret | (r.opcode == OP_MISC_MEM);
    endfunction

endpackage

// File: rtl/decode_nway_serial_if.sv
// Fetch-2 -> decode -> instruction-buffer bundle interface.
// Latency: n/a (wires only).
// Backpressure: decReady_o low tells fetch to hold decPacket_i; stall_i stalls decode.
// Ports: fetchValid_i/decPacket_i/laneActive_i/flush_i/stall_i into decode;
//        decReady_o/ibPacket_o/ibValid_o/serializing_o out of decode.
interface decode_nway_serial_if import decode_nway_serial_pkg::*; #(
    parameter int DECODE_WIDTH = 4
) ();
    logic                    fetchValid_i;
    decPkt                   decPacket_i [DECODE_WIDTH];
    logic [DECODE_WIDTH-1:0] laneActive_i;
    logic                    flush_i;
    logic                    stall_i;
    logic                    decReady_o;
    renPkt                   ibPacket_o [DECODE_WIDTH];
    logic                    ibValid_o;
    logic                    serializing_o;

    // Fetch / environment side
    modport master (
        output fetchValid_i, decPacket_i, laneActive_i, flush_i, stall_i,
        input  decReady_o, ibPacket_o, ibValid_o, serializing_o
    );

    // Decode stage side
    modport slave (
        input  fetchValid_i, decPacket_i, laneActive_i, flush_i, stall_i,
        output decReady_o, ibPacket_o, ibValid_o, serializing_o
    );
endinterface

// File: rtl/decode_nway_serial_lane.sv
// Single-lane RV64 decoder: one decPkt into one renPkt plus serializing flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the parent registers and stalls.
// Ports: pkt_i raw packet, laneEn_i lane enable, ren_o decoded packet, ser_o serializing.
module decode_lane_rv import decode_nway_serial_pkg::*; (
    input  decPkt pkt_i,
    input  logic  laneEn_i,
    output renPkt ren_o,
    output logic  ser_o
);
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] immI, immS, immSB, immU, immUJ;
    renPkt       r;

    assign inst  = pkt_i.inst;
    assign opc   = inst[6:0];
    assign rd    = inst[11:7];
    assign fn3   = inst[14:12];
    assign rs1   = inst[19:15];
    assign rs2   = inst[24:20];
    assign fn7   = inst[31:25];

    assign immI  = {{20{inst[31]}}, inst[31:20]};
    assign immS  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign immSB = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign immU  = {inst[31:12], 12'b0};
    assign immUJ = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Unused register fields stay zero so invalid fields are clean downstream.
    always_comb begin
        r = '0;
        if (laneEn_i && pkt_i.valid) begin
            r.valid  = 1'b1;
            r.pc     = pkt_i.pc;
            r.opcode = opc;
            r.fn3    = fn3;
            r.fn7    = fn7;
            case (opc)
                OP_LOAD, OP_LOAD_FP: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logDest = {(opc == OP_LOAD_FP), rd}; r.logDestValid = 1'b1;
                    r.imm = immI; r.fuType = FU_MEM; r.isLoad = 1'b1;
                end
                OP_STORE, OP_STORE_FP: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logSrc2 = {(opc == OP_STORE_FP), rs2}; r.logSrc2Valid = 1'b1;
                    r.imm = immS; r.fuType = FU_MEM; r.isStore = 1'b1;
                end
                OP_OP_IMM, OP_OP_IMM_32: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logDest = {1'b0, rd};  r.logDestValid = 1'b1;
                    r.imm = immI; r.fuType = FU_SIMPLE;
                end
                OP_OP, OP_OP_32: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logSrc2 = {1'b0, rs2}; r.logSrc2Valid = 1'b1;
                    r.logDest = {1'b0, rd};  r.logDestValid = 1'b1;
                    r.fuType = (fn7 == FN7_MULDIV) ? FU_COMPLEX : FU_SIMPLE;
                end
                OP_LUI, OP_AUIPC: begin
                    r.logDest = {1'b0, rd}; r.logDestValid = 1'b1;
                    r.imm = immU; r.fuType = FU_SIMPLE;
                end
                OP_BRANCH: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logSrc2 = {1'b0, rs2}; r.logSrc2Valid = 1'b1;
                    r.imm = immSB; r.fuType = FU_CTRL;
                end
                OP_JAL: begin
                    r.logDest = {1'b0, rd}; r.logDestValid = 1'b1;
                    r.imm = immUJ; r.fuType = FU_CTRL;
                end
                OP_JALR: begin
                    r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                    r.logDest = {1'b0, rd};  r.logDestValid = 1'b1;
                    r.imm = immI; r.fuType = FU_CTRL;
                end
                OP_OP_FP: begin
                    r.logSrc1 = {1'b1, rs1}; r.logSrc1Valid = 1'b1;
                    r.logSrc2 = {1'b1, rs2}; r.logSrc2Valid = 1'b1;
                    r.logDest = {1'b1, rd};  r.logDestValid = 1'b1;
                    r.fuType = FU_FP;
                    // Moves/compares/converts cross between register files.
                    case (fn7[6:2])
                        5'b11100, 5'b10100, 5'b11000: r.logDest = {1'b0, rd};
                        5'b11110, 5'b11010:           r.logSrc1 = {1'b0, rs1};
                        default: ;
                    endcase
                end
                OP_MISC_MEM: begin
                    r.fuType = FU_SYS;
                end
                OP_SYSTEM: begin
                    r.fuType = FU_SYS;
                    r.imm = {20'b0, inst[31:20]};
                    if (fn3 == FN3_PRIV) begin
                        case (inst[31:20])
                            FN12_ECALL: begin
                                r.isScall = 1'b1; r.exception = 1'b1;
                                r.exceptionCause = CAUSE_ECALL;
                            end
                            FN12_EBREAK: begin
                                r.isSbreak = 1'b1; r.exception = 1'b1;
                                r.exceptionCause = CAUSE_BREAKPOINT;
                            end
                            FN12_SRET: r.isSret = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        r.isCSR = 1'b1;
                        r.logDest = {1'b0, rd}; r.logDestValid = 1'b1;
                        // fn3[2] selects the zimm forms, where rs1 is not a register.
                        if (!fn3[2]) begin
                            r.logSrc1 = {1'b0, rs1}; r.logSrc1Valid = 1'b1;
                        end
                    end
                end
                default: begin
                    r.exception = 1'b1;
                    r.exceptionCause = CAUSE_ILLEGAL_INST;
                end
            endcase
            // Writes to x0 are discarded, so they never claim a destination.
            if (r.logDest == 6'd0) begin
                r.logDestValid = 1'b0;
            end
        end
    end

    assign ren_o = r;
    assign ser_o = r.valid & is_serializing(r);
endmodule

// File: rtl/decode_nway_serial.sv
// N-wide decode stage; splits bundles so serializing instructions issue alone.
// Latency: 1 cycle (registered output); a bundle with k groups takes k unstalled cycles.
// Backpressure: stall_i holds all state; decReady_o only on the last group of a bundle.
// Ports: clk, reset_n (sync active-low), bus (slave side of decode_nway_serial_if).
module decode_nway_serial import decode_nway_serial_pkg::*; #(
    parameter int DECODE_WIDTH = 4,
    parameter int LANE_LOG     = $clog2(DECODE_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    decode_nway_serial_if.slave  bus
);
    renPkt                   laneRen [DECODE_WIDTH];
    logic [DECODE_WIDTH-1:0] ser;

    dec_state_t              state_q;
    logic [LANE_LOG-1:0]     startLane_q, startLane_d;
    renPkt                   ibPacket_q [DECODE_WIDTH];
    renPkt                   ibPacket_d [DECODE_WIDTH];
    logic                    ibValid_q, ibValid_d;

    logic [LANE_LOG-1:0]     grpEnd;
    logic                    startSer, found, lastGroup;

    genvar g;
    generate
        for (g = 0; g < DECODE_WIDTH; g++) begin : g_lane
            decode_lane_rv u_lane (
                .pkt_i    (bus.decPacket_i[g]),
                .laneEn_i (bus.laneActive_i[g] & bus.fetchValid_i),
                .ren_o    (laneRen[g]),
                .ser_o    (ser[g])
            );
            assign bus.ibPacket_o[g] = ibPacket_q[g];
        end
    endgenerate

    // Group end: a serializing start lane stands alone; otherwise stop just
    // before the oldest serializing lane after startLane, or at the last lane.
    always_comb begin
        startSer = 1'b0;
        found    = 1'b0;
        grpEnd   = LANE_LOG'(DECODE_WIDTH - 1);
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (LANE_LOG'(i) == startLane_q && ser[i]) begin
                startSer = 1'b1;
            end
        end
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (!found && LANE_LOG'(i) > startLane_q && ser[i]) begin
                grpEnd = LANE_LOG'(i - 1);
                found  = 1'b1;
            end
        end
        if (startSer) begin
            grpEnd = startLane_q;
        end
    end

    assign lastGroup   = (grpEnd == LANE_LOG'(DECODE_WIDTH - 1));
    assign startLane_d = grpEnd + LANE_LOG'(1);

    // Slots keep their lane position; everything outside the group is blank.
    always_comb begin
        ibValid_d = 1'b0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            ibPacket_d[i] = '0;
            if (LANE_LOG'(i) >= startLane_q && LANE_LOG'(i) <= grpEnd) begin
                ibPacket_d[i] = laneRen[i];
            end
            ibValid_d = ibValid_d | ibPacket_d[i].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= DEC_IDLE;
            startLane_q <= '0;
            ibValid_q   <= 1'b0;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                ibPacket_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            // Remaining groups of the current bundle are abandoned.
            state_q     <= DEC_IDLE;
            startLane_q <= '0;
            ibValid_q   <= 1'b0;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                ibPacket_q[i].valid <= 1'b0;
            end
        end else if (!bus.stall_i) begin
            ibValid_q <= ibValid_d;
            for (int i = 0; i < DECODE_WIDTH; i++) begin
                ibPacket_q[i] <= ibPacket_d[i];
            end
            if (lastGroup) begin
                state_q     <= DEC_IDLE;
                startLane_q <= '0;
            end else begin
                state_q     <= DEC_SPLIT;
                startLane_q <= startLane_d;
            end
        end
    end

    assign bus.decReady_o    = !bus.stall_i & lastGroup & reset_n & !bus.flush_i;
    assign bus.ibValid_o     = ibValid_q;
    assign bus.serializing_o = (state_q != DEC_IDLE);
endmodule

// File: tb/tb_decode_nway_serial.sv
// Directed bench for decode_nway_serial with a 4-lane configuration.
// Latency: checks outputs one cycle after each drive.
// Backpressure: exercises stall_i, flush_i and reset during split bundles.
module tb_decode_nway_serial;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_nway_serial_if #(.DECODE_WIDTH(4)) bus ();

    decode_nway_serial #(.DECODE_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  dest;  logic destV;
        logic [5:0]  src1;  logic src1V;
        logic [5:0]  src2;  logic src2V;
        logic [31:0] imm;
        logic [2:0]  fu;
        logic [5:0]  flags;   // {load, store, csr, scall, sbreak, sret}
        logic [4:0]  exc;     // {exception, cause}
        logic        ser;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return enc_i(imm, 5'd1, 3'b000, rd, 7'h13);
    endfunction

    localparam logic [31:0] I_ADD   = 32'h003100B3;   // add x1,x2,x3
    localparam logic [31:0] I_CSRRW = 32'h300312F3;   // csrrw x5,0x300,x6
    localparam logic [31:0] I_CSRRS = 32'h300022F3;   // csrrs x5,0x300,x0
    localparam logic [31:0] I_LW    = 32'h01012503;   // lw x10,16(x2)
    localparam logic [31:0] I_FENCE = 32'h0FF0000F;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vmask();
        return {bus.ibPacket_o[3].valid, bus.ibPacket_o[2].valid,
                bus.ibPacket_o[1].valid, bus.ibPacket_o[0].valid};
    endfunction

    // b[0] is lane 0 (oldest)
    task automatic drive(input logic [3:0][31:0] b, input logic [3:0] act);
        for (int i = 0; i < 4; i++) begin
            bus.decPacket_i[i].valid = 1'b1;
            bus.decPacket_i[i].pc    = 32'h100 + 32'(4 * i);
            bus.decPacket_i[i].inst  = b[i];
        end
        bus.laneActive_i = act;
        bus.fetchValid_i = 1'b1;
    endtask

    // Called just after inputs change: checks ready, clocks, checks outputs.
    task automatic cyc(input string nm, input logic expRdy, input logic [3:0] expMask,
                       input logic expSer);
        #1;
        chk({nm, " ready"}, 64'(bus.decReady_o), 64'(expRdy));
        @(posedge clk); #1;
        chk({nm, " mask"}, 64'(vmask()), 64'(expMask));
        chk({nm, " ibValid"}, 64'(bus.ibValid_o), 64'(|expMask));
        chk({nm, " serializing"}, 64'(bus.serializing_o), 64'(expSer));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{addi(5'd5, 12'hFFD), 6'd5,1'b1, 6'd1,1'b1, 6'd0,1'b0, 32'hFFFFFFFD, 3'd0, 6'b000000, 5'h00, 1'b0};
        vecs[1]  = '{enc_r(7'h00,5'd3,5'd2,3'd0,5'd0,7'h33), 6'd0,1'b0, 6'd2,1'b1, 6'd3,1'b1, 32'h0, 3'd0, 6'b000000, 5'h00, 1'b0};
        vecs[2]  = '{enc_r(7'h01,5'd9,5'd8,3'd0,5'd7,7'h33), 6'd7,1'b1, 6'd8,1'b1, 6'd9,1'b1, 32'h0, 3'd1, 6'b000000, 5'h00, 1'b0};
        vecs[3]  = '{enc_i(12'd16,5'd2,3'b010,5'd10,7'h03), 6'd10,1'b1, 6'd2,1'b1, 6'd0,1'b0, 32'd16, 3'd3, 6'b100000, 5'h00, 1'b0};
        vecs[4]  = '{enc_s(12'hFF8,5'd0,5'd4,3'b011,7'h23), 6'd0,1'b0, 6'd4,1'b1, 6'd0,1'b1, 32'hFFFFFFF8, 3'd3, 6'b010000, 5'h00, 1'b0};
        vecs[5]  = '{enc_i(12'd4,5'd1,3'b010,5'd3,7'h07), 6'd35,1'b1, 6'd1,1'b1, 6'd0,1'b0, 32'd4, 3'd3, 6'b100000, 5'h00, 1'b0};
        vecs[6]  = '{enc_b(13'd8,5'd2,5'd1,3'd0,7'h63), 6'd0,1'b0, 6'd1,1'b1, 6'd2,1'b1, 32'd8, 3'd2, 6'b000000, 5'h00, 1'b0};
        vecs[7]  = '{enc_u(20'h12345,5'd3,7'h37), 6'd3,1'b1, 6'd0,1'b0, 6'd0,1'b0, 32'h12345000, 3'd0, 6'b000000, 5'h00, 1'b0};
        vecs[8]  = '{enc_j(21'h1FFFFC,5'd1,7'h6F), 6'd1,1'b1, 6'd0,1'b0, 6'd0,1'b0, 32'hFFFFFFFC, 3'd2, 6'b000000, 5'h00, 1'b0};
        vecs[9]  = '{32'h00000073, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 32'h0, 3'd5, 6'b000100, 5'h18, 1'b1};
        vecs[10] = '{32'h00100073, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 32'h1, 3'd5, 6'b000010, 5'h13, 1'b1};
        vecs[11] = '{32'h10200073, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 32'h102, 3'd5, 6'b000001, 5'h00, 1'b1};
        vecs[12] = '{I_CSRRW, 6'd5,1'b1, 6'd6,1'b1, 6'd0,1'b0, 32'h300, 3'd5, 6'b001000, 5'h00, 1'b1};
        vecs[13] = '{I_FENCE, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 32'h0, 3'd5, 6'b000000, 5'h00, 1'b1};
        vecs[14] = '{32'h0000007F, 6'd0,1'b0, 6'd0,1'b0, 6'd0,1'b0, 32'h0, 3'd0, 6'b000000, 5'h12, 1'b0};

        // Reset state
        reset_n = 1'b0;
        bus.fetchValid_i = 1'b0;
        bus.laneActive_i = 4'hF;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        for (int i = 0; i < 4; i++) bus.decPacket_i[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset ready", 64'(bus.decReady_o), 64'd0);
        chk("reset mask", 64'(vmask()), 64'd0);
        chk("reset ibValid", 64'(bus.ibValid_o), 64'd0);
        chk("reset serializing", 64'(bus.serializing_o), 64'd0);
        reset_n = 1'b1;

        // Single-instruction decode table, instruction in lane 0 only
        for (int k = 0; k < 15; k++) begin
            drive({I_ADD, I_ADD, I_ADD, vecs[k].inst}, 4'b0001);
            #1;
            chk($sformatf("v%0d ready", k), 64'(bus.decReady_o), 64'(!vecs[k].ser));
            @(posedge clk); #1;
            chk($sformatf("v%0d mask", k), 64'(vmask()), 64'b0001);
            chk($sformatf("v%0d dest", k), 64'({bus.ibPacket_o[0].logDestValid, bus.ibPacket_o[0].logDest}),
                64'({vecs[k].destV, vecs[k].dest}));
            chk($sformatf("v%0d src1", k), 64'({bus.ibPacket_o[0].logSrc1Valid, bus.ibPacket_o[0].logSrc1}),
                64'({vecs[k].src1V, vecs[k].src1}));
            chk($sformatf("v%0d src2", k), 64'({bus.ibPacket_o[0].logSrc2Valid, bus.ibPacket_o[0].logSrc2}),
                64'({vecs[k].src2V, vecs[k].src2}));
            chk($sformatf("v%0d imm", k), 64'(bus.ibPacket_o[0].imm), 64'(vecs[k].imm));
            chk($sformatf("v%0d fu", k), 64'(bus.ibPacket_o[0].fuType), 64'(vecs[k].fu));
            chk($sformatf("v%0d flags", k), 64'({bus.ibPacket_o[0].isLoad, bus.ibPacket_o[0].isStore,
                bus.ibPacket_o[0].isCSR, bus.ibPacket_o[0].isScall, bus.ibPacket_o[0].isSbreak,
                bus.ibPacket_o[0].isSret}), 64'(vecs[k].flags));
            chk($sformatf("v%0d exc", k), 64'({bus.ibPacket_o[0].exception, bus.ibPacket_o[0].exceptionCause}),
                64'(vecs[k].exc));
            chk($sformatf("v%0d serializing", k), 64'(bus.serializing_o), 64'(vecs[k].ser));
            if (vecs[k].ser) cyc($sformatf("v%0d tail", k), 1'b1, 4'b0000, 1'b0);
        end

        // Four ADDI bundles back to back, ready every cycle
        drive({addi(5'd8, 12'h004), addi(5'd7, 12'h123), addi(5'd6, 12'h002), addi(5'd5, 12'h001)}, 4'hF);
        cyc("addi4 a", 1'b1, 4'b1111, 1'b0);
        chk("addi4 a imm2", 64'(bus.ibPacket_o[2].imm), 64'h123);
        chk("addi4 a fu3", 64'(bus.ibPacket_o[3].fuType), 64'd0);
        drive({addi(5'd9, 12'h7FF), addi(5'd9, 12'h800), addi(5'd9, 12'h010), addi(5'd9, 12'h020)}, 4'hF);
        cyc("addi4 b", 1'b1, 4'b1111, 1'b0);
        chk("addi4 b imm2", 64'(bus.ibPacket_o[2].imm), 64'hFFFFF800);
        chk("addi4 b pc3", 64'(bus.ibPacket_o[3].pc), 64'h10C);

        // {ADD, CSRRW, LW, FENCE}: four single-lane groups
        drive({I_FENCE, I_LW, I_CSRRW, I_ADD}, 4'hF);
        cyc("grp4 g0", 1'b0, 4'b0001, 1'b1);
        cyc("grp4 g1", 1'b0, 4'b0010, 1'b1);
        cyc("grp4 g2", 1'b0, 4'b0100, 1'b1);
        cyc("grp4 g3", 1'b1, 4'b1000, 1'b0);
        chk("grp4 g3 fu", 64'(bus.ibPacket_o[3].fuType), 64'd5);

        // Serializing instruction in the last lane finishes the bundle itself
        drive({I_CSRRW, I_ADD, I_ADD, I_ADD}, 4'hF);
        cyc("lastser g0", 1'b0, 4'b0111, 1'b1);
        cyc("lastser g1", 1'b1, 4'b1000, 1'b0);

        // {CSRRS, ADD, ADD, ADD} with a two-cycle stall after the first group
        drive({I_ADD, I_ADD, I_ADD, I_CSRRS}, 4'hF);
        cyc("stall g0", 1'b0, 4'b0001, 1'b1);
        bus.stall_i = 1'b1;
        cyc("stall hold1", 1'b0, 4'b0001, 1'b1);
        cyc("stall hold2", 1'b0, 4'b0001, 1'b1);
        bus.stall_i = 1'b0;
        cyc("stall g1", 1'b1, 4'b1110, 1'b0);

        // Flush (with stall also high) while splitting at startLane=2
        drive({I_ADD, I_FENCE, I_ADD, I_CSRRW}, 4'hF);
        cyc("flush g0", 1'b0, 4'b0001, 1'b1);
        cyc("flush g1", 1'b0, 4'b0010, 1'b1);
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        cyc("flush", 1'b0, 4'b0000, 1'b0);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        drive({addi(5'd4, 12'h4), addi(5'd3, 12'h3), addi(5'd2, 12'h2), addi(5'd1, 12'h1)}, 4'hF);
        cyc("post flush", 1'b1, 4'b1111, 1'b0);
        chk("post flush imm0", 64'(bus.ibPacket_o[0].imm), 64'h1);

        // Lane enables limit the bundle
        drive({addi(5'd4, 12'h4), addi(5'd3, 12'h3), addi(5'd2, 12'h2), addi(5'd1, 12'h1)}, 4'b0011);
        cyc("laneActive", 1'b1, 4'b0011, 1'b0);

        // No fetch in IDLE
        bus.fetchValid_i = 1'b0;
        cyc("no fetch", 1'b1, 4'b0000, 1'b0);

        // Reset for one cycle in the middle of a split bundle
        drive({I_FENCE, I_LW, I_CSRRW, I_ADD}, 4'hF);
        cyc("rst g0", 1'b0, 4'b0001, 1'b1);
        reset_n = 1'b0;
        cyc("rst mid", 1'b0, 4'b0000, 1'b0);
        chk("rst pkt0 zero", 64'(bus.ibPacket_o[0] == '0), 64'd1);
        reset_n = 1'b1;
        drive({addi(5'd4, 12'h4), addi(5'd3, 12'h3), addi(5'd2, 12'h2), addi(5'd1, 12'h1)}, 4'hF);
        cyc("post rst", 1'b1, 4'b1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
